csi_rx_pkt_ctrl: RTL and testbench



---
 rtl/csi_rx_pkt_ctrl_if.sv | 33 +++
 rtl/csi_rx_pkt_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_csi_rx_pkt_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/csi_rx_pkt_ctrl_if.sv
// Stream bundle for the CSI-2 packet controller: aligned HS words in,
// AXI-Stream style video payload out.
interface csi_rx_pkt_ctrl_if;
   logic        DIN_VALID;
   logic [31:0] DIN;
   logic        M_VALID;
   logic [31:0] M_DATA;
   logic [3:0]  M_STRB;
   logic        M_LAST;
   logic        M_USER;

   // Controller side: consumes aligned words, produces payload beats.
   modport slave (
      input  DIN_VALID,
      input  DIN,
      output M_VALID,
      output M_DATA,
      output M_STRB,
      output M_LAST,
      output M_USER
   );

   // Source/sink side: drives aligned words, observes payload beats.
   modport master (
      output DIN_VALID,
      output DIN,
      input  M_VALID,
      input  M_DATA,
      input  M_STRB,
      input  M_LAST,
      input  M_USER
   );
endinterface

// File: rtl/csi_rx_pkt_ctrl.sv
// CSI-2 receive packet controller: header parse with ECC check, frame/line
// sequencing from short packets, payload forwarding of the selected long
// packet type with SOF/EOL marking, and sticky debug error flags.
module csi_rx_pkt_ctrl #(
   parameter logic [1:0] VC_SEL = 2'd0,
   parameter logic [5:0] DT_SEL = 6'h2B
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   csi_rx_pkt_ctrl_if.slave         bus,
   input  logic                     ERR_CLR,
   output logic                     FS_PULSE,
   output logic                     FE_PULSE,
   output logic                     FRAME_ACTIVE,
   output logic [15:0]              LINE_COUNT,
   output logic                     ERR_ECC,
   output logic                     ERR_TRUNC
);

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

   // Row masks of the CSI-2 header Hamming code over the 24 data bits.
   localparam logic [23:0] ECC_M0 = 24'hF12CB7;
   localparam logic [23:0] ECC_M1 = 24'hF2555B;
   localparam logic [23:0] ECC_M2 = 24'h749A6D;
   localparam logic [23:0] ECC_M3 = 24'hB8E38E;
   localparam logic [23:0] ECC_M4 = 24'hDF03F0;
   localparam logic [23:0] ECC_M5 = 24'hEFFC00;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_LONG_MIN = 6'h10;

   // Six-bit ECC of a 24-bit packet header (DI + WC).
   function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & ECC_M0);
      p[1] = ^(d & ECC_M1);
      p[2] = ^(d & ECC_M2);
      p[3] = ^(d & ECC_M3);
      p[4] = ^(d & ECC_M4);
      p[5] = ^(d & ECC_M5);
      return p;
   endfunction

   state_e      state_q, state_d;
   logic [15:0] remain_q, remain_d;
   logic        sof_pend_q, sof_pend_d;
   logic        frame_active_q, frame_active_d;
   logic [15:0] line_count_q, line_count_d;
   logic        fs_pulse_q, fs_pulse_d;
   logic        fe_pulse_q, fe_pulse_d;
   logic        err_ecc_q, err_ecc_d;
   logic        err_trunc_q, err_trunc_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_data_q, m_data_d;
   logic [3:0]  m_strb_q, m_strb_d;
   logic        m_last_q, m_last_d;
   logic        m_user_q, m_user_d;

   logic [1:0]  hdr_vc_s;
   logic [5:0]  hdr_dt_s;
   logic [15:0] hdr_wc_s;
   logic        hdr_ecc_ok_s;

   assign hdr_vc_s     = bus.DIN[7:6];
   assign hdr_dt_s     = bus.DIN[5:0];
   assign hdr_wc_s     = bus.DIN[23:8];
   assign hdr_ecc_ok_s = (hdr_ecc(bus.DIN[23:0]) == bus.DIN[29:24]);

   // State and output registers; reset aborts any packet in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q        <= ST_HDR;
         remain_q       <= 16'd0;
         sof_pend_q     <= 1'b0;
         frame_active_q <= 1'b0;
         line_count_q   <= 16'd0;
         fs_pulse_q     <= 1'b0;
         fe_pulse_q     <= 1'b0;
         err_ecc_q      <= 1'b0;
         err_trunc_q    <= 1'b0;
         m_valid_q      <= 1'b0;
         m_data_q       <= 32'd0;
         m_strb_q       <= 4'd0;
         m_last_q       <= 1'b0;
         m_user_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         remain_q       <= remain_d;
         sof_pend_q     <= sof_pend_d;
         frame_active_q <= frame_active_d;
         line_count_q   <= line_count_d;
         fs_pulse_q     <= fs_pulse_d;
         fe_pulse_q     <= fe_pulse_d;
         err_ecc_q      <= err_ecc_d;
         err_trunc_q    <= err_trunc_d;
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_strb_q       <= m_strb_d;
         m_last_q       <= m_last_d;
         m_user_q       <= m_user_d;
      end
   end

   // Packet sequencing: header decode, payload slicing and burst draining.
   always_comb begin
      state_d        = state_q;
      remain_d       = remain_q;
      sof_pend_d     = sof_pend_q;
      frame_active_d = frame_active_q;
      line_count_d   = line_count_q;
      fs_pulse_d     = 1'b0;
      fe_pulse_d     = 1'b0;
      // A clear in the same cycle as a new error loses to the error below.
      err_ecc_d      = ERR_CLR ? 1'b0 : err_ecc_q;
      err_trunc_d    = ERR_CLR ? 1'b0 : err_trunc_q;
      m_valid_d      = 1'b0;
      m_data_d       = m_data_q;
      m_strb_d       = 4'd0;
      m_last_d       = 1'b0;
      m_user_d       = 1'b0;

      case (state_q)
         ST_HDR: begin
            if (bus.DIN_VALID) begin
               if (!hdr_ecc_ok_s) begin
                  err_ecc_d = 1'b1;
                  state_d   = ST_DRAIN;
               end else if (hdr_dt_s < DT_LONG_MIN) begin
                  if (hdr_vc_s == VC_SEL) begin
                     if (hdr_dt_s == DT_FS) begin
                        // An FS inside an active frame simply restarts it.
                        frame_active_d = 1'b1;
                        line_count_d   = 16'd0;
                        sof_pend_d     = 1'b1;
                        fs_pulse_d     = 1'b1;
                     end else if ((hdr_dt_s == DT_FE) && frame_active_q) begin
                        frame_active_d = 1'b0;
                        sof_pend_d     = 1'b0;
                        fe_pulse_d     = 1'b1;
                     end else begin
                        frame_active_d = frame_active_q;
                     end
                  end else begin
                     frame_active_d = frame_active_q;
                  end
                  state_d = ST_DRAIN;
               end else if ((hdr_vc_s == VC_SEL) && (hdr_dt_s == DT_SEL) &&
                            frame_active_q && (hdr_wc_s != 16'd0)) begin
                  remain_d = hdr_wc_s;
                  state_d  = ST_PAYLOAD;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               state_d = ST_HDR;
            end
         end

         ST_PAYLOAD: begin
            if (bus.DIN_VALID) begin
               m_valid_d  = 1'b1;
               m_data_d   = bus.DIN;
               m_user_d   = sof_pend_q;
               sof_pend_d = 1'b0;
               if (remain_q > 16'd4) begin
                  m_strb_d = 4'hF;
                  remain_d = remain_q - 16'd4;
               end else begin
                  case (remain_q[2:0])
                     3'd1:    m_strb_d = 4'h1;
                     3'd2:    m_strb_d = 4'h3;
                     3'd3:    m_strb_d = 4'h7;
                     default: m_strb_d = 4'hF;
                  endcase
                  m_last_d = 1'b1;
                  remain_d = 16'd0;
                  if (line_count_q != 16'hFFFF) begin
                     line_count_d = line_count_q + 16'd1;
                  end else begin
                     line_count_d = line_count_q;
                  end
                  state_d = ST_DRAIN;
               end
            end else begin
               // Burst ended mid-payload: the line is abandoned uncounted.
               err_trunc_d = 1'b1;
               remain_d    = 16'd0;
               state_d     = ST_HDR;
            end
         end

         ST_DRAIN: begin
            if (bus.DIN_VALID) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_HDR;
            end
         end

         default: begin
            state_d = ST_HDR;
         end
      endcase
   end

   assign bus.M_VALID   = m_valid_q;
   assign bus.M_DATA    = m_data_q;
   assign bus.M_STRB    = m_strb_q;
   assign bus.M_LAST    = m_last_q;
   assign bus.M_USER    = m_user_q;
   assign FS_PULSE      = fs_pulse_q;
   assign FE_PULSE      = fe_pulse_q;
   assign FRAME_ACTIVE  = frame_active_q;
   assign LINE_COUNT    = line_count_q;
   assign ERR_ECC       = err_ecc_q;
   assign ERR_TRUNC     = err_trunc_q;

endmodule

// File: tb/tb_csi_rx_pkt_ctrl.sv
// Bench for csi_rx_pkt_ctrl: directed packets, expected payload beats queued
// at stimulus time and checked by an independent monitor process.
module tb_csi_rx_pkt_ctrl;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      logic        user;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        err_clr = 1'b0;
   logic        fs_pulse, fe_pulse, frame_active, err_ecc, err_trunc;
   logic [15:0] line_count;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];

   csi_rx_pkt_ctrl_if bus();

   csi_rx_pkt_ctrl #(.VC_SEL(2'd0), .DT_SEL(6'h2B)) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .bus          (bus),
      .ERR_CLR      (err_clr),
      .FS_PULSE     (fs_pulse),
      .FE_PULSE     (fe_pulse),
      .FRAME_ACTIVE (frame_active),
      .LINE_COUNT   (line_count),
      .ERR_ECC      (err_ecc),
      .ERR_TRUNC    (err_trunc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ECC built column-wise: each data bit's syndrome from the CSI-2 table.
   function automatic logic [5:0] ecc_col(input int i);
      case (i)
         0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
         4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
         8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
        12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
        16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
        20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
        default: return 6'h00;
      endcase
   endfunction

   function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                       input logic [15:0] wc);
      logic [23:0] d;
      logic [5:0]  e;
      d = {wc, vc, dt};
      e = 6'h00;
      for (int i = 0; i < 24; i++) begin
         if (d[i]) e = e ^ ecc_col(i);
      end
      return {2'b00, e, d};
   endfunction

   // Drive one input cycle from a negedge and return at the next negedge,
   // where the outputs produced by that word are visible.
   task automatic cyc(input logic v, input logic [31:0] d);
      bus.DIN_VALID = v;
      bus.DIN       = d;
      @(negedge clk);
   endtask

   task automatic gap();
      cyc(1'b0, 32'h0000_0000);
   endtask

   // Long packet burst: header, nwords payload words, optional CRC word, EoT.
   task automatic send_line(input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input int nwords,
                            input logic [31:0] base, input logic expect_out,
                            input logic user1, input logic [3:0] strb_last,
                            input logic complete);
      logic [31:0] w;
      cyc(1'b1, hdr(vc, dt, wc));
      for (int i = 0; i < nwords; i++) begin
         w = base + (32'h0101_0101 * i);
         if (expect_out) begin
            exp_q.push_back('{data: w,
                              strb: (complete && i == nwords - 1) ? strb_last : 4'hF,
                              last: complete && (i == nwords - 1),
                              user: user1 && (i == 0)});
         end
         cyc(1'b1, w);
      end
      if (complete) begin
         cyc(1'b1, 32'hC0C0_FFFF);
         gap();
      end
   endtask

   // Monitor: every beat the DUT presents is matched against the queue.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.M_VALID) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", {32'd0, bus.M_DATA}, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", {26'd0, bus.M_DATA, bus.M_STRB, bus.M_LAST, bus.M_USER},
                      {26'd0, e});
               end
            end else begin
               chk("idle_sideband", {58'd0, bus.M_STRB, bus.M_LAST, bus.M_USER}, 64'd0);
            end
         end
      end
   end

   task automatic chk_all_zero(input string name);
      chk(name, {fs_pulse, fe_pulse, frame_active, err_ecc, err_trunc, line_count,
                 bus.M_VALID, bus.M_STRB, bus.M_LAST, bus.M_USER, bus.M_DATA}, 64'd0);
   endtask

   initial begin
      bus.DIN_VALID = 1'b0;
      bus.DIN       = 32'h0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_state");
      rst_n = 1'b1;
      gap();

      // 1: FS then one WC=10 line -> strobes F,F,3, SOF on beat 1.
      cyc(1'b1, hdr(2'd0, 6'h00, 16'd0));
      chk("t1_fs_pulse", {62'd0, fs_pulse, frame_active}, 64'd3);
      chk("t1_lc_zero", {48'd0, line_count}, 64'd0);
      gap();
      chk("t1_fs_pulse_one_cycle", {63'd0, fs_pulse}, 64'd0);
      send_line(2'd0, 6'h2B, 16'd10, 3, 32'h1000_0000, 1'b1, 1'b1, 4'h3, 1'b1);
      chk("t1_line_count", {48'd0, line_count}, 64'd1);

      // 2: restart frame (reserved header bits set), two WC=8 lines, then FE.
      cyc(1'b1, hdr(2'd0, 6'h00, 16'd0) | 32'hC000_0000);
      chk("t2_fs_restart_lc", {47'd0, fs_pulse, line_count}, {47'd0, 1'b1, 16'd0});
      gap();
      send_line(2'd0, 6'h2B, 16'd8, 2, 32'h2000_0000, 1'b1, 1'b1, 4'hF, 1'b1);
      send_line(2'd0, 6'h2B, 16'd8, 2, 32'h3000_0000, 1'b1, 1'b0, 4'hF, 1'b1);
      chk("t2_line_count", {48'd0, line_count}, 64'd2);
      cyc(1'b1, hdr(2'd0, 6'h01, 16'd0));
      chk("t2_fe", {45'd0, fe_pulse, frame_active, line_count}, {45'd0, 2'b10, 16'd2});
      gap();
      chk("t2_fe_one_cycle", {63'd0, fe_pulse}, 64'd0);

      // 3: corrupted FS header -> ERR_ECC only; clear; clear vs. set.
      cyc(1'b1, hdr(2'd0, 6'h00, 16'd0) ^ 32'h0000_0100);
      chk("t3_ecc_err", {61'd0, err_ecc, fs_pulse, frame_active}, 64'd4);
      gap();
      err_clr = 1'b1;
      gap();
      err_clr = 1'b0;
      chk("t3_ecc_clr", {63'd0, err_ecc}, 64'd0);
      err_clr = 1'b1;
      cyc(1'b1, hdr(2'd0, 6'h2B, 16'd8) ^ 32'h0010_0000);
      err_clr = 1'b0;
      chk("t3_set_wins", {63'd0, err_ecc}, 64'd1);
      gap();
      err_clr = 1'b1;
      gap();
      err_clr = 1'b0;
      chk("t3_ecc_clr2", {63'd0, err_ecc}, 64'd0);

      // 4: filtering -- none of these may produce a beat.
      send_line(2'd0, 6'h2B, 16'd8, 2, 32'h4000_0000, 1'b0, 1'b0, 4'hF, 1'b1);
      cyc(1'b1, hdr(2'd0, 6'h00, 16'd0));
      gap();
      send_line(2'd1, 6'h2B, 16'd8, 2, 32'h5000_0000, 1'b0, 1'b0, 4'hF, 1'b1);
      send_line(2'd0, 6'h2A, 16'd8, 2, 32'h6000_0000, 1'b0, 1'b0, 4'hF, 1'b1);
      send_line(2'd0, 6'h2B, 16'd0, 0, 32'h7000_0000, 1'b0, 1'b0, 4'hF, 1'b1);
      chk("t4_filtered_lc", {47'd0, frame_active, line_count}, {47'd0, 1'b1, 16'd0});

      // 5: WC=16 truncated after two words; SOF still pending from the FS.
      send_line(2'd0, 6'h2B, 16'd16, 2, 32'h8000_0000, 1'b1, 1'b1, 4'hF, 1'b0);
      gap();
      chk("t5_trunc", {47'd0, err_trunc, line_count}, {47'd0, 1'b1, 16'd0});
      gap();
      send_line(2'd0, 6'h2B, 16'd4, 1, 32'h9000_0000, 1'b1, 1'b0, 4'hF, 1'b1);
      chk("t5_wc4_lc", {48'd0, line_count}, 64'd1);
      send_line(2'd0, 6'h2B, 16'd5, 2, 32'hA000_0000, 1'b1, 1'b0, 4'h1, 1'b1);
      send_line(2'd0, 6'h2B, 16'd3, 1, 32'hB000_0000, 1'b1, 1'b0, 4'h7, 1'b1);
      chk("t5_after_trunc_lc", {47'd0, err_trunc, line_count}, {47'd0, 1'b1, 16'd3});

      // 6: reset in the middle of a WC=12 payload.
      send_line(2'd0, 6'h2B, 16'd12, 1, 32'hD000_0000, 1'b1, 1'b0, 4'hF, 1'b0);
      rst_n = 1'b0;
      bus.DIN_VALID = 1'b0;
      #1;
      chk_all_zero("t6_reset_mid_payload");
      @(negedge clk);
      rst_n = 1'b1;
      gap();
      cyc(1'b1, hdr(2'd0, 6'h00, 16'd0));
      chk("t6_fs", {62'd0, fs_pulse, frame_active}, 64'd3);
      gap();
      send_line(2'd0, 6'h2B, 16'd6, 2, 32'hE000_0000, 1'b1, 1'b1, 4'h3, 1'b1);
      chk("t6_line", {47'd0, err_trunc, line_count}, {47'd0, 1'b0, 16'd1});

      repeat (2) gap();
      chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
